// File: rtl/ext_sbit_shaper.sv
// HDMI S-bit output shaper: per-channel edge detect, fixed-width pulse, dead time, polarity.
// Optional per-channel saturating trigger counters are built when EXT_SBIT_COUNTERS_EN is defined.
module ext_sbit_shaper #(
    parameter int NUM_OUTPUTS = 8,
    parameter int STRETCH_W   = 4,
    parameter int DEAD_W      = 4,
    parameter int CNT_W       = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_OUTPUTS-1:0]       sbits_i,
    input  logic                         enable_i,
    input  logic [STRETCH_W-1:0]         stretch_len_i,
    input  logic [DEAD_W-1:0]            dead_len_i,
    input  logic [NUM_OUTPUTS-1:0]       invert_i,
    input  logic                         cnt_reset_i,
    output logic [NUM_OUTPUTS-1:0]       hdmi_o,
    output logic [NUM_OUTPUTS-1:0]       busy_o,
    output logic [NUM_OUTPUTS*CNT_W-1:0] cnt_o
);

    localparam int CW = (STRETCH_W > DEAD_W) ? STRETCH_W : DEAD_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_DEAD = 2'd2;

    logic [NUM_OUTPUTS-1:0] sbit_r_q;
    logic [NUM_OUTPUTS-1:0] sbit_rr_q;
    logic [NUM_OUTPUTS-1:0] trig_d;
    logic [NUM_OUTPUTS-1:0] trig_q;
    logic [NUM_OUTPUTS-1:0] hdmi_d;
    logic [NUM_OUTPUTS-1:0] hdmi_q;
    logic [NUM_OUTPUTS-1:0] busy_d;
    logic [NUM_OUTPUTS-1:0] busy_q;
    logic [NUM_OUTPUTS-1:0] accept_s;
    logic [1:0]             state_d [NUM_OUTPUTS];
    logic [1:0]             state_q [NUM_OUTPUTS];
    logic [CW-1:0]          down_d  [NUM_OUTPUTS];
    logic [CW-1:0]          down_q  [NUM_OUTPUTS];

    // Rising-edge detect; the trigger is registered once more so the pulse appears two clocks after sampling.
    always_comb begin
        trig_d = sbit_r_q & ~sbit_rr_q & {NUM_OUTPUTS{enable_i}};
    end

    // Per-channel IDLE/HOLD/DEAD sequencing; settings are latched into the down-counter on state entry.
    always_comb begin
        for (int j = 0; j < NUM_OUTPUTS; j++) begin
            state_d[j]  = state_q[j];
            down_d[j]   = down_q[j];
            accept_s[j] = 1'b0;
            if (!enable_i) begin
                state_d[j] = ST_IDLE;
                down_d[j]  = {CW{1'b0}};
            end else begin
                case (state_q[j])
                    ST_IDLE: begin
                        if (trig_q[j]) begin
                            state_d[j]  = ST_HOLD;
                            down_d[j]   = CW'(stretch_len_i);
                            accept_s[j] = 1'b1;
                        end else begin
                            state_d[j] = ST_IDLE;
                        end
                    end
                    ST_HOLD: begin
                        if (down_q[j] == {CW{1'b0}}) begin
                            // Dead time counts dead_len_i full clocks, so load one less than the setting.
                            if (dead_len_i == {DEAD_W{1'b0}}) begin
                                state_d[j] = ST_IDLE;
                            end else begin
                                state_d[j] = ST_DEAD;
                                down_d[j]  = CW'(dead_len_i) - CW'(1'b1);
                            end
                        end else begin
                            down_d[j] = down_q[j] - CW'(1'b1);
                        end
                    end
                    ST_DEAD: begin
                        if (down_q[j] == {CW{1'b0}}) begin
                            state_d[j] = ST_IDLE;
                        end else begin
                            down_d[j] = down_q[j] - CW'(1'b1);
                        end
                    end
                    default: begin
                        state_d[j] = ST_IDLE;
                        down_d[j]  = {CW{1'b0}};
                    end
                endcase
            end
            hdmi_d[j] = (state_d[j] == ST_HOLD) ^ invert_i[j];
            busy_d[j] = (state_d[j] != ST_IDLE);
        end
    end

    // Input pipeline, channel state and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            sbit_r_q  <= {NUM_OUTPUTS{1'b0}};
            sbit_rr_q <= {NUM_OUTPUTS{1'b0}};
            trig_q    <= {NUM_OUTPUTS{1'b0}};
            hdmi_q    <= {NUM_OUTPUTS{1'b0}};
            busy_q    <= {NUM_OUTPUTS{1'b0}};
            for (int j = 0; j < NUM_OUTPUTS; j++) begin
                state_q[j] <= ST_IDLE;
                down_q[j]  <= {CW{1'b0}};
            end
        end else begin
            sbit_r_q  <= sbits_i;
            sbit_rr_q <= sbit_r_q;
            trig_q    <= trig_d;
            hdmi_q    <= hdmi_d;
            busy_q    <= busy_d;
            for (int j = 0; j < NUM_OUTPUTS; j++) begin
                state_q[j] <= state_d[j];
                down_q[j]  <= down_d[j];
            end
        end
    end

    assign hdmi_o = hdmi_q;
    assign busy_o = busy_q;

`ifdef EXT_SBIT_COUNTERS_EN
    logic [CNT_W-1:0] tcnt_d [NUM_OUTPUTS];
    logic [CNT_W-1:0] tcnt_q [NUM_OUTPUTS];

    // Saturating trigger counters; a clear wins over a coincident accepted trigger.
    always_comb begin
        for (int j = 0; j < NUM_OUTPUTS; j++) begin
            if (cnt_reset_i) begin
                tcnt_d[j] = {CNT_W{1'b0}};
            end else if (accept_s[j] && (tcnt_q[j] != {CNT_W{1'b1}})) begin
                tcnt_d[j] = tcnt_q[j] + CNT_W'(1'b1);
            end else begin
                tcnt_d[j] = tcnt_q[j];
            end
        end
    end

    // Counter storage.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int j = 0; j < NUM_OUTPUTS; j++) begin
                tcnt_q[j] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int j = 0; j < NUM_OUTPUTS; j++) begin
                tcnt_q[j] <= tcnt_d[j];
            end
        end
    end

    // Flatten counters onto the readback bus.
    always_comb begin
        cnt_o = {(NUM_OUTPUTS*CNT_W){1'b0}};
        for (int j = 0; j < NUM_OUTPUTS; j++) begin
            cnt_o[j*CNT_W +: CNT_W] = tcnt_q[j];
        end
    end
`else
    logic unused_s;
    assign unused_s = ^{cnt_reset_i, accept_s};
    assign cnt_o    = {(NUM_OUTPUTS*CNT_W){1'b0}};
`endif

endmodule

// File: doc/ext_sbit_shaper.md
Name: ext_sbit_shaper

Overview:
- Output stage between the HDMI S-bit selector (8 selected trigger bits, one clock per bit) and the HDMI output drivers.
- Per channel, it converts each rising edge into a pulse of programmable width, then holds off further triggers for a programmable dead time, so that downstream scintillator/NIM logic sees clean, fixed-width pulses.
- It also applies per-channel output polarity.
- It optionally keeps per-channel trigger counters that are readable through the slow-control register space.

Parameters:
NUM_OUTPUTS, 8, number of HDMI S-bit channels
STRETCH_W, 4, width of pulse-length setting
DEAD_W, 4, width of dead-time setting
CNT_W, 16, width of each trigger counter

Ports:
clock  in  1  fabric clock (40 MHz LHC clock domain)
reset  in  1  synchronous, active-high reset
sbits_i  in  NUM_OUTPUTS  selected S-bits from the HDMI selector, registered in that block
enable_i  in  1  global enable; low forces all channels idle
stretch_len_i  in  STRETCH_W  output pulse width minus 1, in clocks
dead_len_i  in  DEAD_W  hold-off time after a pulse, in clocks
invert_i  in  NUM_OUTPUTS  per-channel output polarity; 1 = active-low
cnt_reset_i  in  1  synchronous clear of all trigger counters
hdmi_o  out  NUM_OUTPUTS  shaped outputs to the HDMI drivers
busy_o  out  NUM_OUTPUTS  channel is in HOLD or DEAD
cnt_o  out  NUM_OUTPUTS*CNT_W  trigger counters; channel j occupies bits [j*CNT_W +: CNT_W]

Behaviour:
- Reset (synchronous, active-high; clock clock):
  - All channel FSMs go to IDLE and all counters clear.
  - The edge-detect registers clear: sbit_r=0, sbit_rr=0.
  - hdmi_o=0, busy_o=0, cnt_o=0.
  - From the first cycle after reset deasserts, hdmi_o reflects invert_i.
- Input stage:
  - sbits_i is registered into sbit_r, then into sbit_rr.
  - Per channel, trig = sbit_r & ~sbit_rr & enable_i.
- Per-channel FSM, states IDLE, HOLD, DEAD, with a shared down-counter of width max(STRETCH_W,DEAD_W):
  - IDLE: if trig, go to HOLD and load counter with stretch_len_i.
  - HOLD: if counter==0, go to DEAD and load dead_len_i; if dead_len_i==0, go directly to IDLE instead. Otherwise decrement.
  - DEAD: if counter==0, go to IDLE. Otherwise decrement.
  - trig is honoured only in IDLE. Edges arriving in HOLD or DEAD are discarded, not queued.
  - A channel therefore spends at least one IDLE cycle between pulses.
- Settings capture:
  - stretch_len_i is captured on entry to HOLD; dead_len_i is captured on entry to DEAD.
  - Changing either input mid-pulse does not affect a pulse already in progress.
- Outputs (registered):
  - hdmi_o[j] = (next_state==HOLD) ^ invert_i[j].
  - busy_o[j] = (next_state!=IDLE).
- Latency and width:
  - If sbits_i[j] is sampled 0 at edge k-1 and 1 at edge k, hdmi_o[j] is active from edge k+2.
  - It stays active for exactly stretch_len_i+1 clocks.
- Held input: a level held high produces a single pulse. No retrigger occurs until sbits_i drops for at least one clock and rises again.
- enable_i low:
  - All FSMs go to IDLE on the next edge, truncating any active pulse.
  - hdmi_o = invert_i and busy_o = 0.
  - Counters hold their value.
- invert_i is applied combinationally into the output register, so a polarity change takes effect on the next edge.
- Simultaneous events: independent channels triggering in the same cycle are fully independent; there is no shared arbitration.

Optional Feature:
- Macro: EXT_SBIT_COUNTERS_EN.
- Defined:
  - Each channel has a CNT_W counter that increments on every accepted trigger (IDLE to HOLD).
  - The counter saturates at all-ones and never wraps.
  - cnt_reset_i clears all counters. If cnt_reset_i and an accepted trigger occur in the same cycle, the result is 0.
- Undefined: counter logic is not built, cnt_o is tied to 0, and cnt_reset_i is ignored.

Test Plan:
- Single edge, stretch=3, dead=2, invert=0: sbits_i[0] rises at edge 10 → hdmi_o[0] high edges 12-15, low from 16; busy_o[0] high edges 12-17; cnt ch0=1.
- Retrigger during hold-off, stretch=1, dead=4: second rising edge on ch2 while it is in DEAD → no second pulse, counter=1; a third edge after return to IDLE → pulse of 2 clocks, counter=2.
- Held level plus invert: sbits_i[5] held high for 50 clocks with invert_i[5]=1, stretch=0, dead=0 → exactly one 1-clock low pulse on hdmi_o[5], idle high otherwise.
- enable_i dropped mid-pulse (stretch=15) on ch1 → hdmi_o[1]=invert next edge and busy_o[1]=0; counter unchanged.
- Reset mid-pulse, then saturation: assert reset during HOLD → all outputs 0 the next cycle. With CNT_W=4 (macro on), 20 accepted triggers → cnt ch0=15. Asserting cnt_reset_i together with a trigger → 0.
- Macro off: repeat the first scenario → identical hdmi_o/busy_o timing, cnt_o remains 0.
